dram_mp_bist: RTL and testbench

Parametrised multi-channel distributed-RAM block with a built-in self-test (BIST) engine. It generalises the fixed 32-deep, 8-channel, 2-bit LUTRAM feature test. Depth, channel count and data width are parameters. Every channel has its own read address, and all channels share one write port. An on-chip march sequencer writes and checks every location of every channel and reports pass/fail with an error count. The block sits in the feature-test designs, between board switches/LEDs (or a host) and the inferred LUTRAM primitives.

---
 rtl/dram_mp_bist_if.sv | 28 ++
 rtl/dram_mp_bist.sv | 185 ++++++++++++++++++
 tb/tb_dram_mp_bist.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_mp_bist_if.sv
// Bus bundle for dram_mp_bist: shared write port, per-channel read ports and BIST status.
// The testbench or host drives the master side; the RAM block is the slave.
interface dram_mp_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 2,
  parameter int NUM_CH = 8
);
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [NUM_CH*DATA_W-1:0]   wdata;
  logic [NUM_CH*ADDR_W-1:0]   raddr;
  logic [NUM_CH*DATA_W-1:0]   rdata;
  logic                       bist_start;
  logic                       bist_busy;
  logic                       bist_done;
  logic                       bist_pass;
  logic [15:0]                err_count;

  modport master (
    output we, waddr, wdata, raddr, bist_start,
    input  rdata, bist_busy, bist_done, bist_pass, err_count
  );

  modport slave (
    input  we, waddr, wdata, raddr, bist_start,
    output rdata, bist_busy, bist_done, bist_pass, err_count
  );
endinterface

// File: rtl/dram_mp_bist.sv
// Multi-channel distributed RAM (shared write port, per-channel registered reads) with an
// optional march BIST engine, built only when DRAM_MP_BIST_EN is defined.
module dram_mp_bist #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 2,
  parameter int NUM_CH = 8
) (
  input logic            clk,
  input logic            rst,
  dram_mp_bist_if.slave  bif
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [NUM_CH][DEPTH];
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic [NUM_CH*ADDR_W-1:0] mem_raddr;
  logic [NUM_CH*DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mem_q[c][mem_waddr] <= mem_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      rdata_d[c*DATA_W +: DATA_W] = mem_q[c][mem_raddr[c*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign bif.rdata = rdata_q;

`ifdef DRAM_MP_BIST_EN
  typedef enum logic [2:0] {IDLE, FILL0, CHECK0, FILL1, CHECK1, DONE} state_e;

  localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DRAIN  = (ADDR_W+1)'(DEPTH);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input int unsigned c);
    int unsigned s;
    s = 32'(a) + c;
    return s[DATA_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [15:0]       err_q, err_d;
  logic              done_q, done_d, pass_q, pass_d;
  logic              cmp_vld_q, cmp_vld_d, cmp_inv_q, cmp_inv_d;
  logic [ADDR_W-1:0] cmp_a_q, cmp_a_d;
  logic              busy, fill, inv;
  logic [DATA_W-1:0] exp_c;
  logic [15:0]       n_mis;
  logic [16:0]       err_sum;

  always_comb begin
    busy = (state_q == FILL0) || (state_q == CHECK0) || (state_q == FILL1) || (state_q == CHECK1);
    fill = (state_q == FILL0) || (state_q == FILL1);
    inv  = (state_q == FILL1) || (state_q == CHECK1);
  end

  // While busy the engine owns both memory ports; channel c reads (cnt + c) mod DEPTH.
  always_comb begin
    mem_we    = bif.we;
    mem_waddr = bif.waddr;
    mem_wdata = bif.wdata;
    mem_raddr = bif.raddr;
    if (busy) begin
      mem_we    = fill;
      mem_waddr = cnt_q[ADDR_W-1:0];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mem_wdata[c*DATA_W +: DATA_W] = pat(cnt_q[ADDR_W-1:0], c) ^ {DATA_W{inv}};
        mem_raddr[c*ADDR_W +: ADDR_W] = ADDR_W'(32'(cnt_q) + c);
      end
    end
  end

  // Compare stage lags the read issue by one cycle, matching the registered read path.
  always_comb begin
    n_mis = '0;
    exp_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      exp_c = pat(ADDR_W'(32'(cmp_a_q) + c), c) ^ {DATA_W{cmp_inv_q}};
      if (rdata_q[c*DATA_W +: DATA_W] != exp_c) n_mis = n_mis + 16'd1;
    end
    err_sum = {1'b0, err_q} + {1'b0, n_mis};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    if (cmp_vld_q) err_d = err_sum[16] ? '1 : err_sum[15:0];
    cmp_vld_d = ((state_q == CHECK0) || (state_q == CHECK1)) && (cnt_q != DRAIN);
    cmp_a_d   = cnt_q[ADDR_W-1:0];
    cmp_inv_d = (state_q == CHECK1);
    case (state_q)
      IDLE, DONE: begin
        if (bif.bist_start) begin
          state_d = FILL0;
          cnt_d   = '0;
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      FILL0, FILL1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_A) begin
          cnt_d   = '0;
          state_d = (state_q == FILL0) ? CHECK0 : CHECK1;
        end
      end
      CHECK0, CHECK1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN) begin
          cnt_d = '0;
          if (state_q == CHECK0) begin
            state_d = FILL1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_inv_q <= 1'b0;
      cmp_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_inv_q <= cmp_inv_d;
      cmp_a_q   <= cmp_a_d;
    end
  end

  assign bif.bist_busy = busy;
  assign bif.bist_done = done_q;
  assign bif.bist_pass = pass_q;
  assign bif.err_count = err_q;
`else
  logic unused_start;

  always_comb begin
    mem_we    = bif.we;
    mem_waddr = bif.waddr;
    mem_wdata = bif.wdata;
    mem_raddr = bif.raddr;
  end

  assign unused_start  = bif.bist_start;
  assign bif.bist_busy = 1'b0;
  assign bif.bist_done = 1'b0;
  assign bif.bist_pass = 1'b0;
  assign bif.err_count = '0;
`endif
endmodule

// File: tb/tb_dram_mp_bist.sv
// Directed bench for dram_mp_bist: default-size instance plus a 16x4x3 instance, with an
// expected-read scoreboard; BIST steps are exercised when DRAM_MP_BIST_EN is defined.
module tb_dram_mp_bist;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  dram_mp_bist_if #(.ADDR_W(5), .DATA_W(2), .NUM_CH(8)) if0 ();
  dram_mp_bist_if #(.ADDR_W(4), .DATA_W(4), .NUM_CH(3)) if1 ();

  dram_mp_bist #(.ADDR_W(5), .DATA_W(2), .NUM_CH(8)) u0 (.clk(clk), .rst(rst), .bif(if0));
  dram_mp_bist #(.ADDR_W(4), .DATA_W(4), .NUM_CH(3)) u1 (.clk(clk), .rst(rst), .bif(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd0(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'(if0.rdata), e);
    end
  endtask

  task automatic chk_rd1(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'(if1.rdata), e);
    end
  endtask

  function automatic logic [39:0] rep0(input int unsigned a);
    logic [39:0] v;
    for (int c = 0; c < 8; c++) v[c*5 +: 5] = 5'(a);
    return v;
  endfunction

  // Contents left by a completed BIST: mem[c][a] = ~((a + c) mod 2**DATA_W)
  function automatic logic [15:0] inv_pat0(input int unsigned a);
    logic [15:0] v;
    logic [1:0]  p;
    for (int c = 0; c < 8; c++) begin
      p = 2'((a + 32'(c)) % 4);
      v[c*2 +: 2] = ~p;
    end
    return v;
  endfunction

  function automatic logic [11:0] inv_pat1(input int unsigned a);
    logic [11:0] v;
    logic [3:0]  p;
    for (int c = 0; c < 3; c++) begin
      p = 4'((a + 32'(c)) % 16);
      v[c*4 +: 4] = ~p;
    end
    return v;
  endfunction

  task automatic chk_zero0(input string tag);
    chk({tag, "_rdata"}, 64'(if0.rdata), 64'd0);
    chk({tag, "_busy"},  64'(if0.bist_busy), 64'd0);
    chk({tag, "_done"},  64'(if0.bist_done), 64'd0);
    chk({tag, "_pass"},  64'(if0.bist_pass), 64'd0);
    chk({tag, "_err"},   64'(if0.err_count), 64'd0);
  endtask

  // kind 1: re-pulse start plus an external write at cycle inj; kind 2: reset at cycle inj.
  task automatic bist0(input int inj, input int kind, output int cyc);
    if0.bist_start = 1'b1;
    tick();
    if0.bist_start = 1'b0;
    cyc = 0;
    while (if0.bist_busy === 1'b1 && cyc < 1000) begin
      cyc++;
      if (cyc == inj) begin
        if (kind == 1) begin
          if0.bist_start = 1'b1;
          if0.we         = 1'b1;
          if0.waddr      = '0;
          if0.wdata      = '0;
          if0.raddr      = 40'({$urandom, $urandom});
        end else begin
          rst = 1'b1;
        end
      end
      tick();
      if0.bist_start = 1'b0;
      if0.we         = 1'b0;
      rst            = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    logic [15:0] w4;
    logic [15:0] e;

    rst = 1'b1;
    if0.we = 1'($urandom);  if0.waddr = 5'($urandom); if0.wdata = 16'($urandom);
    if0.raddr = 40'({$urandom, $urandom}); if0.bist_start = 1'($urandom);
    if1.we = 1'($urandom);  if1.waddr = 4'($urandom); if1.wdata = 12'($urandom);
    if1.raddr = 12'($urandom); if1.bist_start = 1'($urandom);
    tick();
    tick();
    chk_zero0("reset");
    chk("reset_u1_rdata", 64'(if1.rdata), 64'd0);
    chk("reset_u1_busy",  64'(if1.bist_busy), 64'd0);
    chk("reset_u1_err",   64'(if1.err_count), 64'd0);

    rst = 1'b0;
    if0.bist_start = 1'b0; if1.bist_start = 1'b0;
    if0.we = 1'b0; if1.we = 1'b0;
    tick();

    // Write/read at the default size
    w4 = 16'h5A5A;
    if0.we = 1'b1; if0.waddr = 5'd4; if0.wdata = w4;
    tick();
    if0.waddr = 5'd3; if0.wdata = 16'hE4E4;
    tick();
    if0.we = 1'b0; if0.raddr = rep0(3);
    exp_q.push_back(64'h0000_E4E4);
    tick();
    chk_rd0("rd_addr3");
    if0.raddr[4:0] = 5'd4;
    e = 16'hE4E4;
    e[1:0] = w4[1:0];
    exp_q.push_back(64'(e));
    tick();
    chk_rd0("rd_ch0_addr4");

    // Read-during-write returns the old word
    if0.we = 1'b1; if0.waddr = 5'd7; if0.wdata = '0;
    tick();
    if0.wdata = '1; if0.raddr = rep0(7);
    exp_q.push_back(64'd0);
    tick();
    chk_rd0("rdw_old");
    if0.we = 1'b0;
    exp_q.push_back(64'h0000_FFFF);
    tick();
    chk_rd0("rdw_new");

`ifdef DRAM_MP_BIST_EN
    bist0(-1, 0, cyc);
    chk("bist_busy_cycles", 64'(cyc), 64'd130);
    chk("bist_done", 64'(if0.bist_done), 64'd1);
    chk("bist_pass", 64'(if0.bist_pass), 64'd1);
    chk("bist_err",  64'(if0.err_count), 64'd0);
    foreach (w4[i]) begin end
    for (int a = 0; a < 32; a += 5) begin
      if0.raddr = rep0(a);
      exp_q.push_back(64'(inv_pat0(a)));
      tick();
      chk_rd0("post_bist_rd");
    end

    bist0(40, 1, cyc);
    chk("restart_busy_cycles", 64'(cyc), 64'd130);
    chk("restart_pass", 64'(if0.bist_pass), 64'd1);
    chk("restart_err",  64'(if0.err_count), 64'd0);
    if0.raddr = rep0(0);
    exp_q.push_back(64'(inv_pat0(0)));
    tick();
    chk_rd0("restart_addr0");

    bist0(60, 2, cyc);
    chk("rst_abort_cycles", 64'(cyc), 64'd60);
    chk_zero0("rst_abort");
    bist0(-1, 0, cyc);
    chk("fresh_busy_cycles", 64'(cyc), 64'd130);
    chk("fresh_pass", 64'(if0.bist_pass), 64'd1);

    if1.bist_start = 1'b1;
    tick();
    if1.bist_start = 1'b0;
    cyc = 0;
    while (if1.bist_busy === 1'b1 && cyc < 1000) begin
      cyc++;
      tick();
    end
    chk("u1_busy_cycles", 64'(cyc), 64'd66);
    chk("u1_done", 64'(if1.bist_done), 64'd1);
    chk("u1_pass", 64'(if1.bist_pass), 64'd1);
    chk("u1_err",  64'(if1.err_count), 64'd0);
    if1.raddr = 12'h555;
    exp_q.push_back(64'(inv_pat1(5)));
    tick();
    chk_rd1("u1_post_bist_rd");
`else
    if0.bist_start = 1'b1; if1.bist_start = 1'b1;
    tick();
    if0.bist_start = 1'b0; if1.bist_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("off_busy",    64'(if0.bist_busy), 64'd0);
      chk("off_u1_busy", 64'(if1.bist_busy), 64'd0);
      tick();
    end
    chk("off_done", 64'(if0.bist_done), 64'd0);
    chk("off_err",  64'(if0.err_count), 64'd0);
    if0.raddr = rep0(3);
    exp_q.push_back(64'h0000_E4E4);
    tick();
    chk_rd0("off_rd_addr3");
`endif

    if1.we = 1'b1; if1.waddr = 4'd9; if1.wdata = 12'hABC;
    tick();
    if1.we = 1'b0; if1.raddr = 12'h999;
    exp_q.push_back(64'h0ABC);
    tick();
    chk_rd1("u1_ext_rd");
    if1.raddr = 12'h99A;
    exp_q.push_back(64'h0ABC);
    tick();
    chk("u1_ch0_other_addr_differs", 64'(if1.rdata[11:4]), 64'hAB);
    void'(exp_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
